premuat_ctrl: RTL and testbench

Sequencing controller for the transform-quantization permutation stages (8-, 16- and 32-point input reorder units ahead of the partial butterflies). For each transform block it:
- accepts one row per handshake over two passes (columns, then rows);
- tags each row with its index and pass;
- drives the per-size permutation enables and the forward/inverse select to the premuat_8/16/32 cascade.

It sits between the TQ block scheduler and the 2D transform datapath, one row per beat.

---
 rtl/tq_pkg.sv | 21 ++
 rtl/premuat_ctrl_oreg.sv | 52 +++++
 rtl/premuat_ctrl.sv | 132 +++++++++++++
 tb/tb_premuat_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/tq_pkg.sv
// Shared definitions for the TQ permutation sequencing logic: size codes,
// the row count of each transform size, and the controller FSM states.
package tq_pkg;

  localparam logic [1:0] SIZE_4  = 2'd0;
  localparam logic [1:0] SIZE_8  = 2'd1;
  localparam logic [1:0] SIZE_16 = 2'd2;
  localparam logic [1:0] SIZE_32 = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Rows per pass: 4, 8, 16 or 32.
  function automatic logic [5:0] size_to_n(input logic [1:0] size);
    return 6'd4 << size;
  endfunction

endpackage

// File: rtl/premuat_ctrl_oreg.sv
// Tagged output register toward the transform datapath. It loads on an
// accepted row, holds while the consumer stalls, and empties once taken.
module premuat_ctrl_oreg #(
  parameter int ROW_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             take,
  input  logic [ROW_W-1:0] row_d,
  input  logic             pass_d,
  input  logic             enable_8_d,
  input  logic             enable_16_d,
  input  logic             enable_32_d,
  input  logic             inverse_d,
  input  logic             last_d,
  output logic             valid,
  output logic [ROW_W-1:0] row,
  output logic             pass,
  output logic             enable_8,
  output logic             enable_16,
  output logic             enable_32,
  output logic             inverse,
  output logic             last
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid     <= 1'b0;
      row       <= '0;
      pass      <= 1'b0;
      enable_8  <= 1'b0;
      enable_16 <= 1'b0;
      enable_32 <= 1'b0;
      inverse   <= 1'b0;
      last      <= 1'b0;
    end else if (load) begin
      valid     <= 1'b1;
      row       <= row_d;
      pass      <= pass_d;
      enable_8  <= enable_8_d;
      enable_16 <= enable_16_d;
      enable_32 <= enable_32_d;
      inverse   <= inverse_d;
      last      <= last_d;
    end else if (valid && take) begin
      // Tags stay put after the row is taken; only valid drops.
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/premuat_ctrl.sv
// Sequences one transform block as two passes of N rows, tagging each row
// with index, pass and the premuat_8/16/32 enables plus inverse select.
module premuat_ctrl
  import tq_pkg::*;
#(
  parameter int ROW_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [1:0]       i_size,
  input  logic             i_inverse,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_ready,
  output logic             o_valid,
  output logic             o_enable_8,
  output logic             o_enable_16,
  output logic             o_enable_32,
  output logic             o_inverse,
  output logic [ROW_W-1:0] o_row,
  output logic             o_pass,
  output logic             o_last,
  output logic             o_done,
  output logic             o_busy,
  output state_t           dbg_state
);

  // Handshake: upstream row moves when i_valid && o_ready; downstream row
  // moves when o_valid && i_ready. o_valid and tags never change while
  // o_valid && !i_ready, and o_ready is low whenever the register is stuck.

  state_t           state;
  logic [1:0]       size_q;
  logic             inverse_q;
  logic [ROW_W-1:0] row_q;
  logic             pass_q;
  logic             done_q;

  logic [5:0]       n_rows;
  logic [ROW_W-1:0] last_row;
  logic             at_end;
  logic             accept;
  logic             en_8;
  logic             en_16;
  logic             en_32;

  assign n_rows   = size_to_n(size_q);
  assign last_row = ROW_W'(n_rows - 6'd1);
  assign at_end   = (row_q == last_row);

  assign en_8  = (size_q != SIZE_4);
  assign en_16 = size_q[1];
  assign en_32 = (size_q == SIZE_32);

  assign o_ready   = (state == ST_RUN) && (!o_valid || i_ready);
  assign accept    = i_valid && o_ready;
  assign o_done    = done_q;
  assign o_busy    = (state != ST_IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      size_q    <= SIZE_4;
      inverse_q <= 1'b0;
      row_q     <= '0;
      pass_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A start landing on the done pulse belongs to the finished block.
          if (i_start && !done_q) begin
            size_q    <= i_size;
            inverse_q <= i_inverse;
            row_q     <= '0;
            pass_q    <= 1'b0;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (accept) begin
            if (at_end) begin
              if (!pass_q) begin
                row_q  <= '0;
                pass_q <= 1'b1;
              end else begin
                state <= ST_DRAIN;
              end
            end else begin
              row_q <= row_q + ROW_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (!o_valid || i_ready) begin
            done_q <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  premuat_ctrl_oreg #(
    .ROW_W(ROW_W)
  ) u_oreg (
    .clk         (clk),
    .rst         (rst),
    .load        (accept),
    .take        (i_ready),
    .row_d       (row_q),
    .pass_d      (pass_q),
    .enable_8_d  (en_8),
    .enable_16_d (en_16),
    .enable_32_d (en_32),
    .inverse_d   (inverse_q),
    .last_d      (pass_q && at_end),
    .valid       (o_valid),
    .row         (o_row),
    .pass        (o_pass),
    .enable_8    (o_enable_8),
    .enable_16   (o_enable_16),
    .enable_32   (o_enable_32),
    .inverse     (o_inverse),
    .last        (o_last)
  );

endmodule

// File: tb/tb_premuat_ctrl.sv
// Directed bench for premuat_ctrl: block sequencing, stalls, gaps, reset
// mid-block and back-to-back starts.
module tb_premuat_ctrl;
  import tq_pkg::*;

  localparam int ROW_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_start;
  logic [1:0]       i_size;
  logic             i_inverse;
  logic             i_valid;
  logic             o_ready;
  logic             i_ready;
  logic             o_valid;
  logic             o_enable_8;
  logic             o_enable_16;
  logic             o_enable_32;
  logic             o_inverse;
  logic [ROW_W-1:0] o_row;
  logic             o_pass;
  logic             o_last;
  logic             o_done;
  logic             o_busy;
  state_t           dbg_state;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  premuat_ctrl #(.ROW_W(ROW_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_size      (i_size),
    .i_inverse   (i_inverse),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_ready     (i_ready),
    .o_valid     (o_valid),
    .o_enable_8  (o_enable_8),
    .o_enable_16 (o_enable_16),
    .o_enable_32 (o_enable_32),
    .o_inverse   (o_inverse),
    .o_row       (o_row),
    .o_pass      (o_pass),
    .o_last      (o_last),
    .o_done      (o_done),
    .o_busy      (o_busy),
    .dbg_state   (dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, o_valid, 0);
    chk({tag, "_ready"}, o_ready, 0);
    chk({tag, "_en8"},   o_enable_8, 0);
    chk({tag, "_en16"},  o_enable_16, 0);
    chk({tag, "_en32"},  o_enable_32, 0);
    chk({tag, "_inv"},   o_inverse, 0);
    chk({tag, "_row"},   o_row, 0);
    chk({tag, "_pass"},  o_pass, 0);
    chk({tag, "_last"},  o_last, 0);
    chk({tag, "_done"},  o_done, 0);
    chk({tag, "_busy"},  o_busy, 0);
  endtask

  // start_mode: 0 pulse start, 1 block already started, 2 pulse start plus a
  // stray start mid-block, 3 hold start high throughout.
  // ready_mode: 0 i_ready always 1, 1 i_ready toggles 1/0.
  // Entered and left just after a rising edge.
  task automatic run_block(input logic [1:0] size, input logic inv,
                           input int ready_mode, input int gap, input int start_mode);
    int n;
    int beats;
    int sent;
    int gapc;
    bit prev_acc;
    bit prev_hold;
    bit last_prev;
    bit done_seen;
    bit acc;
    logic [ROW_W-1:0] prev_row;
    logic prev_pass;
    logic prev_last;
    n = 4 << size;
    beats = 0; sent = 0; gapc = 0;
    prev_acc = 0; prev_hold = 0; last_prev = 0; done_seen = 0;
    prev_row = '0; prev_pass = 0; prev_last = 0;
    i_valid = 0;
    i_ready = 1;
    if (start_mode != 1) begin
      i_start   = 1;
      i_size    = size;
      i_inverse = inv;
      @(posedge clk); #1;
      if (start_mode != 3) i_start = 0;
      chk("busy_after_start", o_busy, 1);
    end
    for (int cyc = 0; cyc < 1000 && !done_seen; cyc++) begin
      i_valid = (sent < 2 * n) && (gapc == 0);
      i_ready = (ready_mode == 1) ? (cyc % 2 == 0) : 1'b1;
      if (start_mode == 2) begin
        i_start = (cyc == 3);
        if (cyc == 3) begin
          i_size    = 2'd3;
          i_inverse = ~inv;
        end
      end
      @(negedge clk);
      chk("valid_model", o_valid, prev_acc || prev_hold);
      if (prev_hold) begin
        chk("hold_row",  o_row,  prev_row);
        chk("hold_pass", o_pass, prev_pass);
        chk("hold_last", o_last, prev_last);
      end
      if (o_valid && !i_ready) chk("ready_in_stall", o_ready, 0);
      if (o_done) begin
        chk("done_after_last", last_prev, 1);
        chk("busy_on_done", o_busy, 0);
        done_seen = 1;
      end
      last_prev = 0;
      if (o_valid && i_ready) begin
        chk("row",  o_row,  beats % n);
        chk("pass", o_pass, beats / n);
        chk("last", o_last, beats == 2 * n - 1);
        chk("en8",  o_enable_8,  size >= 1);
        chk("en16", o_enable_16, size >= 2);
        chk("en32", o_enable_32, size == 3);
        chk("inv",  o_inverse, inv);
        last_prev = (beats == 2 * n - 1);
        beats++;
      end
      acc = i_valid && o_ready;
      if (acc) begin
        sent++;
        gapc = gap;
      end else if (gapc > 0) begin
        gapc--;
      end
      prev_acc  = acc;
      prev_hold = o_valid && !i_ready;
      prev_row  = o_row;
      prev_pass = o_pass;
      prev_last = o_last;
      @(posedge clk); #1;
    end
    chk("done_seen", done_seen, 1);
    chk("beat_count", beats, 2 * n);
    i_valid = 0;
    @(negedge clk);
    chk("done_one_cycle", o_done, 0);
    chk("no_restart_on_done", o_busy, 0);
    @(posedge clk); #1;
    if (start_mode == 3) begin
      i_start = 0;
      @(negedge clk);
      chk("restart_after_done", o_busy, 1);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int acc_cnt;
    rst = 1; i_start = 0; i_size = 0; i_inverse = 0; i_valid = 0; i_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("idle_ready", o_ready, 0);
    @(posedge clk); #1;

    run_block(2'd2, 1'b0, 0, 0, 0);
    run_block(2'd0, 1'b1, 0, 0, 2);
    run_block(2'd3, 1'b0, 1, 0, 0);
    run_block(2'd1, 1'b0, 0, 2, 0);

    // Reset after row 5 of pass 0 has been accepted.
    i_start = 1; i_size = 2'd3; i_inverse = 0;
    @(posedge clk); #1;
    i_start = 0; i_valid = 1; i_ready = 1;
    acc_cnt = 0;
    for (int c = 0; c < 50 && acc_cnt < 6; c++) begin
      @(negedge clk);
      if (i_valid && o_ready) acc_cnt++;
      @(posedge clk); #1;
    end
    chk("rows_before_rst", acc_cnt, 6);
    rst = 1; i_valid = 0;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk_reset_outputs("midblock_rst");
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("no_done_after_rst", o_done, 0);
    end
    @(posedge clk); #1;
    run_block(2'd3, 1'b0, 0, 0, 0);

    run_block(2'd1, 1'b1, 0, 0, 3);
    run_block(2'd1, 1'b1, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
